// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer.
// After reset release it waits out the power-up period with NOPs, then issues
// PRECHARGE ALL, AREF_NUM AUTO REFRESH commands and LOAD MODE REGISTER, and
// finally raises init_done, which stays high until the next reset.
// Every command pin is registered; the command register is loaded from the
// next-state decode, so a command state lasts exactly one cycle.
module sdram_init_seq #(
    parameter int          T_PWR    = 26600,
    parameter int          T_RP     = 3,
    parameter int          T_RFC    = 9,
    parameter int          T_MRD    = 2,
    parameter int          AREF_NUM = 8,
    parameter logic [12:0] MODE_VAL = 13'h037,
    parameter int          CNT_W    = 16
) (
    input  logic        clk_133,
    input  logic        rst_n,
    output logic        sdr_cke,
    output logic        sdr_cs_n,
    output logic        sdr_ras_n,
    output logic        sdr_cas_n,
    output logic        sdr_we_n,
    output logic [1:0]  sdr_ba,
    output logic [12:0] sdr_addr,
    output logic        init_done
);

    localparam int REF_W = $clog2(AREF_NUM + 1);

    // Delay reload values: each wait is T cycles from the command cycle, so the
    // counter is loaded with T-1 on entry and the move happens when it reads 0.
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(AREF_NUM);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;

    typedef enum logic [2:0] {
        S_PWR,
        S_PRE,
        S_WRP,
        S_AREF,
        S_WRFC,
        S_LMR,
        S_WMRD,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_cnt_dec;
    logic              w_cnt_zero;
    logic [REF_W-1:0]  r_ref;
    logic [REF_W-1:0]  w_ref_next;
    logic              r_cke;
    logic [3:0]        r_cmd;
    logic [3:0]        w_cmd_next;
    logic [12:0]       r_addr;
    logic [12:0]       w_addr_next;
    logic              r_done;

    assign w_cnt_zero = (r_cnt == '0);
    // Saturating decrement: the counter never wraps below zero.
    assign w_cnt_dec  = w_cnt_zero ? '0 : (r_cnt - 1'b1);

    // Next-state, delay counter and refresh counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_cnt_dec;
        w_ref_next   = r_ref;
        case (r_state)
            S_PWR: begin
                // cke still low means this is the first clock after reset:
                // start the power-up wait here so cycle 0 counts as a NOP cycle.
                if (!r_cke) begin
                    w_cnt_next = PWR_LOAD;
                end else if (w_cnt_zero) begin
                    w_state_next = S_PRE;
                    w_cnt_next   = RP_LOAD;
                end
            end
            S_PRE:  w_state_next = S_WRP;
            S_WRP: begin
                if (w_cnt_zero) begin
                    w_state_next = S_AREF;
                    w_cnt_next   = RFC_LOAD;
                    w_ref_next   = r_ref + 1'b1;
                end
            end
            S_AREF: w_state_next = S_WRFC;
            S_WRFC: begin
                if (w_cnt_zero) begin
                    if (r_ref == REF_LAST) begin
                        w_state_next = S_LMR;
                        w_cnt_next   = MRD_LOAD;
                    end else begin
                        w_state_next = S_AREF;
                        w_cnt_next   = RFC_LOAD;
                        w_ref_next   = r_ref + 1'b1;
                    end
                end
            end
            S_LMR:  w_state_next = S_WMRD;
            S_WMRD: begin
                if (w_cnt_zero) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: w_cnt_next = '0;
            default: begin
                w_state_next = S_PWR;
                w_cnt_next   = '0;
                w_ref_next   = '0;
            end
        endcase
    end

    // Command decode from the state being entered, so pins and state align.
    always_comb begin
        w_cmd_next  = CMD_NOP;
        w_addr_next = '0;
        case (w_state_next)
            S_PRE: begin
                w_cmd_next  = CMD_PRE;
                w_addr_next = ADDR_PRE_ALL;
            end
            S_AREF: w_cmd_next = CMD_AREF;
            S_LMR: begin
                w_cmd_next  = CMD_LMR;
                w_addr_next = MODE_VAL;
            end
            default: begin
                w_cmd_next  = CMD_NOP;
                w_addr_next = '0;
            end
        endcase
    end

    // State, counters and registered SDRAM pins.
    always_ff @(posedge clk_133 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_PWR;
            r_cnt   <= '0;
            r_ref   <= '0;
            r_cke   <= 1'b0;
            r_cmd   <= CMD_NOP;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ref   <= w_ref_next;
            r_cke   <= 1'b1;
            r_cmd   <= w_cmd_next;
            r_addr  <= w_addr_next;
            r_done  <= (w_state_next == S_DONE);
        end
    end

    assign sdr_cke   = r_cke;
    assign sdr_cs_n  = r_cmd[3];
    assign sdr_ras_n = r_cmd[2];
    assign sdr_cas_n = r_cmd[1];
    assign sdr_we_n  = r_cmd[0];
    // Bank address is zero for every command this block issues.
    assign sdr_ba    = 2'b00;
    assign sdr_addr  = r_addr;
    assign init_done = r_done;

endmodule
